// File: rtl/wb_arb_pkg.sv
// Shared types and source indices for the execution-unit writeback arbiter.
package wb_arb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NSRC_DEFAULT = 4;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_LSU = 3;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] data;
    logic [4:0]              rd_addr;
    logic [XLEN_DEFAULT-1:0] tag;
  } wb_req_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source writeback FIFO: DEPTH entries of wb_req_t, head visible while non-empty.
module wb_src_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  logic    pop_i,
  input  wb_req_t din_i,
  output logic    full_o,
  output logic    empty_o,
  output wb_req_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/exu_wb_arb.sv
// Round-robin writeback arbiter from the execution units to the regfile write port.
// Define WB_ARB_BYPASS_EN to let an empty source compete directly from its inputs.
module exu_wb_arb
  import wb_arb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NSRC  = NSRC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [NSRC*5-1:0]    src_rd_addr,
  input  logic [NSRC*XLEN-1:0] src_tag,
  output logic [NSRC-1:0]      src_ready,
  output logic [XLEN-1:0]      wb_data,
  output logic [4:0]           wb_rd_addr,
  output logic                 wb_rd_wr_en,
  output logic [XLEN-1:0]      wb_instr_tag,
  output logic                 wb_busy,
  output logic                 wb_overflow
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  wb_req_t          in_req [NSRC];
  wb_req_t          head   [NSRC];
  wb_req_t          win;
  wb_req_t          out_q;
  logic [NSRC-1:0]  full, empty, accept, store, byp, cand, push, pop, grant_oh;
  logic             grant_vld;
  logic [PW-1:0]    grant_idx, rr_q, rr_d;
  logic             wen_q, ovf_q;

  function automatic int wrap_idx(int a);
    return a % NSRC;
  endfunction

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign in_req[i]    = '{data:    src_data[i*XLEN +: XLEN],
                            rd_addr: src_rd_addr[i*5 +: 5],
                            tag:     src_tag[i*XLEN +: XLEN]};
    assign src_ready[i] = !rst && !full[i];
    assign accept[i]    = src_valid[i] && src_ready[i];
    // rd_addr==0 completes the handshake but is never written.
    assign store[i]     = accept[i] && (in_req[i].rd_addr != 5'd0);
`ifdef WB_ARB_BYPASS_EN
    assign byp[i]       = empty[i] && store[i];
`else
    assign byp[i]       = 1'b0;
`endif
    assign cand[i]      = !empty[i] || byp[i];
    assign pop[i]       = grant_oh[i] && !empty[i];
    assign push[i]      = store[i] && !(grant_oh[i] && empty[i]);

    wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push[i]),
      .pop_i  (pop[i]),
      .din_i  (in_req[i]),
      .full_o (full[i]),
      .empty_o(empty[i]),
      .head_o (head[i])
    );
  end

  // First candidate at or after rr_q, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (!grant_vld && cand[wrap_idx(int'(rr_q) + k)]) begin
        grant_vld                            = 1'b1;
        grant_idx                            = PW'(wrap_idx(int'(rr_q) + k));
        grant_oh[wrap_idx(int'(rr_q) + k)]   = 1'b1;
      end
    end
  end

`ifdef WB_ARB_BYPASS_EN
  assign win = empty[grant_idx] ? in_req[grant_idx] : head[grant_idx];
`else
  assign win = head[grant_idx];
`endif

  assign rr_d = grant_vld ? PW'(wrap_idx(int'(grant_idx) + 1)) : rr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      wen_q <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      wen_q <= grant_vld;
      if (grant_vld) out_q <= win;
      if (|(src_valid & ~src_ready)) ovf_q <= 1'b1;
    end
  end

  assign wb_data      = out_q.data;
  assign wb_rd_addr   = out_q.rd_addr;
  assign wb_instr_tag = out_q.tag;
  assign wb_rd_wr_en  = wen_q;
  assign wb_overflow  = ovf_q;
  assign wb_busy      = (|(~empty)) || wen_q;

endmodule
